// File: rtl/multi_clock_gen_pkg.sv
// Shared constants and config FSM encoding for the programmable divider bank.
package multi_clock_gen_pkg;

    localparam int unsigned CH_IDX_W      = 3;
    localparam int unsigned CNT_W         = 32;
    localparam int unsigned DEFAULT_DIV_C = 1;

    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/multi_clock_gen_if.sv
// Divisor configuration port: valid/ready request carrying target channel and divisor.
interface multi_clock_gen_if #(
    parameter int unsigned DIV_W = 16
);
    import multi_clock_gen_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [DIV_W-1:0]    cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_div, output cfg_ready);

endinterface

// File: rtl/multi_clock_gen_clk_div_ch.sv
// One divided-clock channel: phase counter, toggle flop, divisor register and rise counter.
module clk_div_ch
    import multi_clock_gen_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             terminal,
    output logic             active_c
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

    assign active_c = en && (div_q != '0);
    assign terminal = active_c && (cnt_q == (div_q - DIV_W'(1)));

    // Sync beats everything; a load in a terminal cycle keeps that cycle's toggle.
    always_comb begin
        div_d     = load ? load_div : div_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        if (sync || !active_c) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (terminal) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (load) begin
            cnt_d = '0;
        end
        rise_d     = clk_out_d & ~clk_out_q;
        rise_cnt_d = rise_cnt_q + CNT_W'(rise_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DIV_W'(DEFAULT_DIV);
            cnt_q      <= '0;
            clk_out_q  <= 1'b0;
            rise_q     <= 1'b0;
            rise_cnt_q <= '0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            clk_out_q  <= clk_out_d;
            rise_q     <= rise_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign rise_pulse = rise_q;
    assign rise_cnt   = rise_cnt_q;

endmodule

// File: rtl/multi_clock_gen.sv
// Programmable divider bank: NUM_CH divided clocks with runtime glitch-free divisor updates.
module multi_clock_gen
    import multi_clock_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_clock_gen_if.slave        cfg,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic [NUM_CH*CNT_W-1:0] rise_cnt,
    output logic                    cfg_err
);

    cfg_state_e          state_q, state_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_err_q, cfg_err_d;
    logic [CH_IDX_W-1:0] sh_ch_q, sh_ch_d;
    logic [DIV_W-1:0]    sh_div_q, sh_div_d;

    logic                accept_c;
    logic                bad_ch_c;
    logic [NUM_CH-1:0]   load_c;
    logic [NUM_CH-1:0]   terminal;
    logic [NUM_CH-1:0]   active_c;

    // Pending divisor lands on a half-period boundary, an idle channel, or sync.
    always_comb begin
        accept_c = cfg.cfg_valid && cfg_ready_q;
        bad_ch_c = 32'(cfg.cfg_ch) >= NUM_CH;
        load_c   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load_c[i] = (state_q == CFG_PEND) && (sh_ch_q == CH_IDX_W'(i))
                        && (sync || terminal[i] || !active_c[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_ch_d   = sh_ch_q;
        sh_div_d  = sh_div_q;
        cfg_err_d = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                if (accept_c) begin
                    if (bad_ch_c) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d  = CFG_PEND;
                        sh_ch_d  = cfg.cfg_ch;
                        sh_div_d = cfg.cfg_div;
                    end
                end
            end
            CFG_PEND: begin
                if (|load_c) begin
                    state_d = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
        cfg_ready_d = (state_d == CFG_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CFG_IDLE;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            sh_ch_q     <= '0;
            sh_div_q    <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            sh_ch_q     <= sh_ch_d;
            sh_div_q    <= sh_div_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg_err       = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (ch_en[g]),
            .sync      (sync),
            .load      (load_c[g]),
            .load_div  (sh_div_q),
            .clk_out   (clk_out[g]),
            .rise_pulse(rise_pulse[g]),
            .rise_cnt  (rise_cnt[g*CNT_W +: CNT_W]),
            .terminal  (terminal[g]),
            .active_c  (active_c[g])
        );
    end

endmodule

// File: doc/multi_clock_gen.md
Name: multi_clock_gen

Overview:
- Single-clock programmable divider bank. It generates NUM_CH divided clock outputs that drive the per-channel clock inputs of the multi-clock counter block.
- Maintains a 32-bit rising-edge count per channel that mirrors the counter block's registers, so benches compare the two directly.
- Divisors are programmed at runtime through a valid/ready config port. Updates are glitch-free and take effect on half-period boundaries.

Parameters:
- NUM_CH, 6: number of generated clocks (1..8).
- DIV_W, 16: divisor width.
- DEFAULT_DIV, 1: divisor for every channel after reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config port can accept a request.
- cfg_ch  input  3  target channel index.
- cfg_div  input  DIV_W  new divisor; 0 = channel parked low.
- ch_en  input  NUM_CH  per-channel run enable.
- sync  input  1  single-cycle pulse; phase-aligns all channels.
- clk_out  output  NUM_CH  generated clocks; registered, no combinational path.
- rise_pulse  output  NUM_CH  one-cycle strobe in the cycle clk_out[i] becomes 1.
- rise_cnt  output  NUM_CH*32  per-channel rising-edge count; channel i occupies bits [32i+31:32i].
- cfg_err  output  1  one-cycle strobe when cfg_ch >= NUM_CH is accepted.

Behaviour:
- Reset values:
  - clk_out = 0, rise_pulse = 0, rise_cnt = 0, cfg_err = 0.
  - cfg_ready = 1.
  - all divisors = DEFAULT_DIV; phase counters = 0; config FSM in IDLE.
- Per channel i, with active divisor D (D >= 1) and ch_en[i] = 1:
  - Phase counter cnt counts 0..D-1.
  - At cnt == D-1: cnt <= 0 and clk_out[i] toggles. Otherwise cnt increments.
  - Output period = 2*D clk cycles at 50% duty. The first toggle occurs D cycles after counting starts.
- On every 0->1 transition of clk_out[i], in the same cycle it becomes visible:
  - rise_pulse[i] = 1;
  - rise_cnt[i] increments by 1, wrapping 0xFFFFFFFF -> 0.
- D == 0 or ch_en[i] = 0:
  - cnt held at 0; clk_out[i] <= 0 on the next edge; no rise pulse is generated.
  - On re-enable, counting restarts from 0.
- sync = 1 has highest priority:
  - all cnt <= 0 and all clk_out <= 0 on the next edge;
  - pending config is applied in the same cycle;
  - rise_cnt is not cleared;
  - a toggle scheduled for that cycle is suppressed.
- Config FSM (IDLE, PEND):
  - IDLE: cfg_ready = 1. On cfg_valid & cfg_ready:
    - valid channel: latch {cfg_ch, cfg_div} into the shadow register and go to PEND.
    - cfg_ch >= NUM_CH: pulse cfg_err next cycle and stay in IDLE.
  - PEND: cfg_ready = 0. The shadow value is applied to the target channel's divisor at the first of:
    - a terminal cycle (cnt == D-1) on that channel; the toggle in that cycle still happens using the old D;
    - the channel being idle (ch_en = 0 or active D == 0), applied at the next edge;
    - sync.
    After applying, cnt restarts at 0 under the new D and the FSM returns to IDLE.
  - cfg_valid held while cfg_ready = 0 is not accepted; the requester keeps it stable.
- Asynchronous reset mid-operation:
  - returns everything to the reset values immediately;
  - a pending config is discarded.

Decomposition:
- Shared package: CH_IDX_W = 3, the config FSM state encoding (IDLE = 0, PEND = 1), and the default-divisor constant.
- One sub-module, clk_div_ch: a single channel holding the phase counter, toggle flop, divisor register, rise detector and 32-bit rise counter.
  - Inputs: en, sync, load, load_div.
  - Outputs: clk_out, rise_pulse, rise_cnt, terminal.
  - The top level instantiates NUM_CH copies and holds the config FSM.

Test Plan:
- Reset defaults: release rst_n with all ch_en = 1 and D = 1 -> each clk_out toggles every cycle (period 2); after 20 cycles each rise_cnt = 10.
- Divisor programming: write ch2 D = 3 while it is running -> cfg_ready falls the cycle after acceptance; the new D is applied at the next terminal cycle; thereafter ch2 has period 6, and ch0 (D = 1) is unaffected.
- Enable and park:
  - Drop ch_en[4] while clk_out[4] = 1 -> output low on the next edge, rise_cnt[4] frozen.
  - Re-enable with D = 2 -> first rise 2 cycles later.
  - Write D = 0 -> output held low and cfg applied within 1 cycle.
- Sync alignment: channels at D = 1, 2, 5 with arbitrary phases, pulse sync -> all clk_out = 0 on the next edge; all rise together after 1, 2 and 5 cycles respectively.
- Error and wrap:
  - Write cfg_ch = 7 -> cfg_err pulses for 1 cycle, FSM stays in IDLE, no divisor changes.
  - Force a rise_cnt to 0xFFFFFFFF (backdoor) -> the next rise gives rise_cnt = 0.
- Reset mid-PEND: accept ch1 D = 8, then assert rst_n low before it is applied -> after release ch1 runs at D = 1 and cfg_ready = 1.
